// File: rtl/ptlrx_pkg.sv
// ptlrx_pkg -- shared types and constants for the pulse-timing receiver array.
//   chan_state_t : per-channel state (INIT / IDLE / BLANK)
//   DROP_W       : width of the saturating drop counter
//   sat_add      : saturating add of an event count onto a DROP_W-bit counter
package ptlrx_pkg;

  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    BLANK = 2'd2
  } chan_state_t;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] base,
                                                input int unsigned       inc);
    int unsigned sum;
    sum = 32'(base) + inc;
    if (sum > ((32'd1 << DROP_W) - 32'd1)) return '1;
    return DROP_W'(sum);
  endfunction

endpackage

// File: rtl/ptlrx_chan.sv
// ptlrx_chan -- one receiver channel.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle strobe, moves the channel out of INIT
//   a        : toggle-encoded pulse input
//   q        : toggle-encoded output, one toggle per accepted pulse, DELAY cycles later
//   drop     : high in the cycle a pulse is rejected by the blanking window
module ptlrx_chan
  import ptlrx_pkg::*;
#(
  parameter int DELAY = 5,
  parameter int CT    = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a,
  output logic q,
  output logic drop
);

  localparam int CW = (CT < 1) ? 1 : $clog2(CT + 1);

  chan_state_t      state, state_nx;
  logic [CW-1:0]    bcnt, bcnt_nx;
  logic [DELAY-1:0] sr;
  logic             a_q;
  logic             pulse;
  logic             accept;

  assign pulse = a ^ a_q;

  // NOTE: the previous-level copy tracks a even during reset and INIT; it is a
  // plain sample, so leaving it out of reset keeps held levels from looking like pulses.
  always_ff @(posedge clk) begin
    a_q <= a;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state)
      INIT: if (start) state_nx = IDLE;
      IDLE: begin
        if (pulse) begin
          accept = 1'b1;
          if (CT > 0) begin
            state_nx = BLANK;
            bcnt_nx  = CW'(CT);
          end
        end
      end
      BLANK: begin
        // Drops do not touch bcnt: the window is anchored to the accepted pulse.
        drop = pulse;
        if (bcnt == CW'(1)) state_nx = IDLE;
        else                bcnt_nx  = bcnt - CW'(1);
      end
      default: state_nx = INIT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge
  // values. The toggle shift register is reset as well, since in-flight pulses
  // must never survive a reset onto q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      bcnt  <= '0;
      sr    <= '0;
      q     <= 1'b0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      // One bit per pending pulse keeps overlapping pulses distinct and ordered.
      sr    <= (sr << 1) | DELAY'(accept);
      q     <= q ^ sr[DELAY-1];
    end
  end

endmodule

// File: rtl/ptlrx_array.sv
// ptlrx_array -- N_CH independent pulse receivers with shared start-up timer
// and shared saturating drop counter.
//   clk, rst : clock, synchronous active-high reset
//   a        : per-channel toggle-encoded pulse inputs
//   err_clr  : clears viol and drop_cnt (a same-cycle drop still registers)
//   q        : per-channel toggle-encoded delayed outputs
//   viol     : sticky per-channel blanking-violation flags
//   drop_cnt : saturating count of dropped pulses over all channels
//   ready    : high once BEGIN_TIME cycles have passed since reset release
module ptlrx_array
  import ptlrx_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DELAY      = 5,
  parameter int CT         = 11,
  parameter int BEGIN_TIME = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   a,
  input  logic              err_clr,
  output logic [N_CH-1:0]   q,
  output logic [N_CH-1:0]   viol,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              ready
);

  localparam int BW = $clog2(BEGIN_TIME + 1);

  logic [BW-1:0]   begin_cnt;
  logic            start;
  logic [N_CH-1:0] drop;
  int unsigned     n_drop;

  // begin_cnt equals the number of edges since release, so start fires on
  // edge BEGIN_TIME counting the first released edge as edge 0.
  assign start = !ready && (begin_cnt == BW'(BEGIN_TIME));

  always_ff @(posedge clk) begin
    if (rst) begin
      begin_cnt <= '0;
      ready     <= 1'b0;
    end else if (!ready) begin
      if (start) ready     <= 1'b1;
      else       begin_cnt <= begin_cnt + BW'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    ptlrx_chan #(
      .DELAY (DELAY),
      .CT    (CT)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a[i]),
      .q     (q[i]),
      .drop  (drop[i])
    );
  end

  always_comb begin
    n_drop = 0;
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + 32'(drop[i]);
  end

  // Clear is applied to the old value before this cycle's drops are merged,
  // so a drop coinciding with err_clr is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol     <= '0;
      drop_cnt <= '0;
    end else begin
      viol     <= (err_clr ? '0 : viol) | drop;
      drop_cnt <= sat_add(err_clr ? '0 : drop_cnt, n_drop);
    end
  end

endmodule

// File: tb/tb_ptlrx_array.sv
// tb_ptlrx_array -- self-checking bench for ptlrx_array (default parameters).
// A per-channel event model (last accept time, queue of due toggle times)
// predicts q/viol/drop_cnt/ready every cycle; literal checks pin known timings.
module tb_ptlrx_array;

  localparam int N_CH       = 4;
  localparam int DELAY      = 5;
  localparam int CT         = 11;
  localparam int BEGIN_TIME = 8;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] a;
  logic            err_clr;
  logic [N_CH-1:0] q;
  logic [N_CH-1:0] viol;
  logic [7:0]      drop_cnt;
  logic            ready;

  ptlrx_array #(
    .N_CH       (N_CH),
    .DELAY      (DELAY),
    .CT         (CT),
    .BEGIN_TIME (BEGIN_TIME)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .err_clr  (err_clr),
    .q        (q),
    .viol     (viol),
    .drop_cnt (drop_cnt),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int              t;              // index of the edge just taken
  int              rel;            // first edge with rst low
  int              last_acc [N_CH];
  int              dueq     [N_CH][$];
  logic [N_CH-1:0] prev_a;
  logic [N_CH-1:0] q_m;
  logic [N_CH-1:0] viol_m;
  int              cnt_m;
  logic            ready_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, t, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] dropv;
    int              ndrop;
    dropv = '0;
    ndrop = 0;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        dueq[c].delete();
        last_acc[c] = -1000000;
      end
      q_m     = '0;
      viol_m  = '0;
      cnt_m   = 0;
      ready_m = 1'b0;
      rel     = t + 1;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (dueq[c].size() > 0 && dueq[c][0] == t) begin
          void'(dueq[c].pop_front());
          q_m[c] = ~q_m[c];
        end
        if ((a[c] != prev_a[c]) && (t - rel > BEGIN_TIME)) begin
          if (t - last_acc[c] > CT) begin
            last_acc[c] = t;
            dueq[c].push_back(t + DELAY);
          end else begin
            dropv[c] = 1'b1;
            ndrop++;
          end
        end
      end
      viol_m  = (err_clr ? '0 : viol_m) | dropv;
      cnt_m   = (err_clr ? 0 : cnt_m) + ndrop;
      if (cnt_m > 255) cnt_m = 255;
      ready_m = (t - rel >= BEGIN_TIME);
    end
    prev_a = a;
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    t++;
    model_edge();
    #1;
    check("q",        32'(q),        32'(q_m));
    check("viol",     32'(viol),     32'(viol_m));
    check("drop_cnt", 32'(drop_cnt), 32'(cnt_m));
    check("ready",    32'(ready),    32'(ready_m));
  endtask

  task automatic run_to(input int e);
    while (t < e) step();
  endtask

  task automatic pulse_at(input int ch, input int e);
    run_to(e - 1);
    a[ch] = ~a[ch];
    step();
  endtask

  initial begin
    int p;
    rst     = 1'b1;
    a       = '0;
    err_clr = 1'b0;
    prev_a  = '0;
    q_m     = '0;
    viol_m  = '0;
    cnt_m   = 0;
    ready_m = 1'b0;
    rel     = 0;
    t       = -5;
    for (int c = 0; c < N_CH; c++) last_acc[c] = -1000000;

    run_to(-1);
    rst = 1'b0;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_q",     32'(q),     32'd0);

    // Pulse during INIT is ignored; ready rises at edge 8.
    pulse_at(0, 3);
    run_to(7);
    check("ready_e7", 32'(ready), 32'd0);
    step();
    check("ready_e8",  32'(ready), 32'd1);
    check("init_q",    32'(q),     32'd0);
    check("init_viol", 32'(viol),  32'd0);

    // Single pulse: toggle exactly DELAY edges later.
    pulse_at(1, 20);
    run_to(24);
    check("q1_e24", 32'(q[1]), 32'd0);
    step();
    check("q1_e25", 32'(q[1]), 32'd1);

    // Second pulse inside the blanking window is dropped.
    pulse_at(2, 30);
    run_to(34);
    check("q2_e34", 32'(q[2]), 32'd0);
    step();
    check("q2_e35", 32'(q[2]), 32'd1);
    pulse_at(2, 41);
    check("viol_e41",  32'(viol),     32'h4);
    check("dcnt_e41",  32'(drop_cnt), 32'd1);
    run_to(46);
    check("q2_e46",    32'(q[2]),     32'd1);
    check("q1_e46",    32'(q[1]),     32'd1);

    run_to(54);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_viol", 32'(viol),     32'd0);
    check("clr_dcnt", 32'(drop_cnt), 32'd0);

    // Pulse just after the window is accepted.
    pulse_at(2, 60);
    pulse_at(2, 72);
    run_to(65);
    check("q2_e65", 32'(q[2]), 32'd0);
    run_to(76);
    check("q2_e76", 32'(q[2]), 32'd0);
    step();
    check("q2_e77",   32'(q[2]), 32'd1);
    check("viol_e77", 32'(viol), 32'd0);

    // Seven drops on ch0, then drops on ch0+ch3 together with err_clr.
    pulse_at(0, 80);
    for (int e = 81; e <= 87; e++) begin
      run_to(e - 1);
      a[0] = ~a[0];
      if (e == 86) a[3] = ~a[3];
      step();
    end
    check("dcnt_e87", 32'(drop_cnt), 32'd7);
    check("viol_e87", 32'(viol),     32'h1);
    a[0]    = ~a[0];
    a[3]    = ~a[3];
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("viol_e88", 32'(viol),     32'h9);
    check("dcnt_e88", 32'(drop_cnt), 32'd2);

    // Saturation.
    for (int k = 0; k < 340; k++) begin
      a[0] = ~a[0];
      step();
    end
    check("dcnt_sat", 32'(drop_cnt), 32'd255);

    // Reset with a pulse in flight.
    repeat (20) step();
    a[0] = ~a[0];
    step();
    p = t;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_q",    32'(q),        32'd0);
    check("rst_dcnt", 32'(drop_cnt), 32'd0);
    for (int k = 0; k <= 8; k++) begin
      step();
      check("rst_q_hold", 32'(q),     32'd0);
      check("rst_ready",  32'(ready), (k >= 8) ? 32'd1 : 32'd0);
    end
    if (t < p + DELAY) check("rst_window", 32'(t), 32'(p + DELAY));

    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      int span;
      span = (((c / 300) % 2) == 1) ? 2 : 14;
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, span) == 0) a[ch] = ~a[ch];
      err_clr = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 599) == 0);
      step();
    end
    rst     = 1'b0;
    err_clr = 1'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ptlrx_array.md
PTLRX_ARRAY -- requirements
Module: ptlrx_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent receiver channels (>=1).
REQ-002 SHALL have parameter DELAY, default 5: a-to-q latency in clk cycles (>=1).
REQ-003 SHALL have parameter CT, default 11: critical-timing blanking window in cycles after each accepted pulse (>=0).
REQ-004 SHALL have parameter BEGIN_TIME, default 8: cycles after reset release before any input is accepted (>=1).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 a  input  N_CH  toggle-encoded pulse inputs; each level change is one pulse.
REQ-008 err_clr  input  1  clears viol and drop_cnt.
REQ-009 q  output  N_CH  toggle-encoded outputs; each toggle is one delivered pulse.
REQ-010 viol  output  N_CH  sticky per-channel timing-violation flags.
REQ-011 drop_cnt  output  8  saturating total count of dropped pulses, all channels.
REQ-012 ready  output  1  high once the BEGIN_TIME window has elapsed.

Function
REQ-013 "Pulse sampled at edge k" SHALL mean the rising edge k where a[i] differs from the copy of a[i] registered at edge k-1.
REQ-014 Per-channel states SHALL be INIT, IDLE and BLANK.
REQ-015 INIT: pulses ignored, no q toggle, no viol; the registered copy of a tracks a, so a level held at INIT exit produces no pulse.
REQ-016 All channels SHALL leave INIT for IDLE, and ready SHALL rise, at edge BEGIN_TIME after the last edge with rst high.
REQ-017 IDLE with pulse at edge k: pulse accepted; q[i] toggles at edge k+DELAY; state goes to BLANK for CT cycles, or stays IDLE if CT=0.
REQ-018 BLANK: pulses sampled at edges k+1..k+CT are dropped; a pulse at k+CT+1 is accepted.
REQ-019 Dropped pulse SHALL set viol[i] at the same edge, produce no q toggle and not restart the blanking window.
REQ-020 Accepted pulses in flight SHALL be independent: CT<DELAY gives several pending toggles per channel, each delivered in order and never merged.
REQ-021 drop_cnt SHALL add the number of channels dropping a pulse in that cycle (0..N_CH) and saturate at 255.
REQ-022 err_clr SHALL clear viol and drop_cnt at that edge; a drop in the same cycle wins: its viol bit stays set and drop_cnt equals that cycle's drop count.
REQ-023 Channels SHALL share no state except ready and drop_cnt.

Reset
REQ-024 While rst is high: q=0, viol=0, drop_cnt=0, ready=0, all delay pipelines cleared, all channels in INIT, begin counter reloaded.
REQ-025 Reset mid-operation SHALL discard all in-flight toggles; none appears on q after reset.

Structure
REQ-026 Package ptlrx_pkg SHALL hold the channel-state enum typedef (INIT/IDLE/BLANK) and the DROP_W=8 localparam.
REQ-027 Sub-module ptlrx_chan SHALL implement one channel (edge detect, blank FSM and counter, DELAY-deep toggle shift register) and be instantiated N_CH times.
REQ-028 Top level SHALL hold the begin counter, ready, the drop adder/saturator and err_clr handling.

Verification (defaults; rst high through edge -1, released from edge 0)
REQ-029 a[0] toggles, sampled at edge 3 -> q stays 0, viol stays 0; ready rises at edge 8.
REQ-030 a[1] pulse sampled at edge 20 -> q[1] toggles exactly once at edge 25; viol=0.
REQ-031 a[2] pulses at 30 and 41 -> q[2] toggles at 35 only; viol[2]=1 and drop_cnt=1 at edge 41. Pulses at 30 and 42 -> toggles at 35 and 47, no viol.
REQ-032 Drops on ch0 and ch3 sampled at the same edge as err_clr=1, with drop_cnt=7 before -> viol=4'b1001, drop_cnt=2.
REQ-033 300 dropped pulses on ch0 -> drop_cnt holds at 255.
REQ-034 Pulse on a[0] at edge 50, rst high at edge 52 -> q=0 after reset, no toggle at edge 55, ready low until 8 edges after release.
